// File: rtl/axis_demux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_demux : 1:N AXI-Stream packet router with registered data/skid output
// Revision   : 1.0
// ----------------------------------------------------------------------------
module axis_demux #(
    parameter int PORTS          = 2,
    parameter int PORT_BITS      = (PORTS > 1) ? $clog2(PORTS) : 1,
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 1,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    input  logic [PORT_BITS-1:0]      s_axis_tdest,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     mn_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     mn_axis_tkeep,
    output logic [USER_WIDTH-1:0]     mn_axis_tuser,
    output logic                      mn_axis_tlast,
    output logic [PORTS-1:0]          mn_axis_tvalid,
    input  logic [PORTS-1:0]          mn_axis_tready,
    output logic                      busy,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_pass = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    localparam logic [PORT_BITS:0] c_port_limit = (PORT_BITS + 1)'(PORTS);
    localparam int c_beat_w = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1 + PORT_BITS;

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [PORT_BITS-1:0]      r_dest;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      r_ready;

    logic                      w_accept;
    logic                      w_first;
    logic                      w_dest_ok;
    logic                      w_route;
    logic                      w_drop_done;
    logic [PORT_BITS-1:0]      w_beat_dest;
    logic [c_beat_w-1:0]       w_beat;

    logic [c_beat_w-1:0]       r_main;
    logic [c_beat_w-1:0]       r_skid;
    logic                      r_main_valid;
    logic                      r_skid_valid;
    logic                      w_main_valid_next;
    logic                      w_skid_valid_next;
    logic                      w_main_load;
    logic                      w_main_from_skid;
    logic                      w_skid_load;
    logic                      w_take;
    logic [PORT_BITS-1:0]      w_main_dest;

    assign w_accept  = s_axis_tvalid && r_ready;
    assign w_first   = (r_state == c_st_idle);
    assign w_dest_ok = ({1'b0, s_axis_tdest} < c_port_limit);

    // State register: routing state, latched destination and drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_dest     <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && w_first && w_dest_ok) begin
                r_dest <= s_axis_tdest;
            end
            if (w_drop_done) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && !s_axis_tlast) begin
                    w_state_next = w_dest_ok ? c_st_pass : c_st_drop;
                end
            end
            c_st_pass, c_st_drop: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy        = (r_state != c_st_idle);
        w_beat_dest = w_first ? s_axis_tdest : r_dest;
        w_route     = w_accept && (w_first ? w_dest_ok : (r_state == c_st_pass));
        w_drop_done = w_accept && s_axis_tlast &&
                      (w_first ? !w_dest_ok : (r_state == c_st_drop));
    end

    assign w_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, w_beat_dest};

    assign w_main_dest = r_main[PORT_BITS-1:0];
    assign w_take      = r_main_valid && mn_axis_tready[w_main_dest];

    // Skid only ever fills while the main register is stalled; ready is low whenever it is full
    always_comb begin
        w_main_valid_next = r_main_valid;
        w_skid_valid_next = r_skid_valid;
        w_main_load       = 1'b0;
        w_main_from_skid  = 1'b0;
        w_skid_load       = 1'b0;
        if (!r_main_valid || w_take) begin
            if (r_skid_valid) begin
                w_main_from_skid  = 1'b1;
                w_main_valid_next = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_route) begin
                w_main_load       = 1'b1;
                w_main_valid_next = 1'b1;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_route) begin
            w_skid_load       = 1'b1;
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
            r_ready      <= !w_skid_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_main_from_skid) begin
            r_main <= r_skid;
        end else if (w_main_load) begin
            r_main <= w_beat;
        end
        if (w_skid_load) begin
            r_skid <= w_beat;
        end
    end

    assign s_axis_tready  = r_ready;
    assign drop_cnt       = r_drop_cnt;
    assign mn_axis_tlast  = r_main[PORT_BITS];
    assign mn_axis_tuser  = r_main[PORT_BITS+1 +: USER_WIDTH];
    assign mn_axis_tkeep  = r_main[PORT_BITS+1+USER_WIDTH +: KEEP_WIDTH];
    assign mn_axis_tdata  = r_main[PORT_BITS+1+USER_WIDTH+KEEP_WIDTH +: DATA_WIDTH];
    assign mn_axis_tvalid = {{(PORTS-1){1'b0}}, r_main_valid} << w_main_dest;

endmodule
`default_nettype wire

// File: doc/axis_demux.md
Name: axis_demux

Overview:
1:N AXI-Stream packet router, the fan-out counterpart of the packet-level N:1 stream mux. It is used to split a single shared DMA/stream path to per-channel consumers. The destination port is sampled from s_axis_tdest on the first beat of each packet and held until tlast. The output stage is fully registered (data register plus skid register) so that neither the data path nor the ready path contains a combinational timing path. Packets addressed to a non-existent port are consumed and discarded, and each one is counted.

Parameters:
PORTS, 2, number of output ports (2..16)
PORT_BITS, $clog2(PORTS), width of the destination field (minimum 1)
DATA_WIDTH, 64, tdata width
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
USER_WIDTH, 1, tuser width
DROP_CNT_WIDTH, 16, width of the dropped-packet counter

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  synchronous reset, active-low
s_axis_tdata  input  DATA_WIDTH  input data
s_axis_tkeep  input  KEEP_WIDTH  input byte enables
s_axis_tuser  input  USER_WIDTH  input user sideband
s_axis_tdest  input  PORT_BITS  destination; significant only on the first beat of a packet
s_axis_tlast  input  1  end of packet
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready (registered)
mn_axis_tdata  output  DATA_WIDTH  output data, broadcast to all ports
mn_axis_tkeep  output  KEEP_WIDTH  output byte enables, broadcast
mn_axis_tuser  output  USER_WIDTH  output user sideband, broadcast
mn_axis_tlast  output  1  end of packet, broadcast
mn_axis_tvalid  output  PORTS  per-port valid; at most one bit set at any time
mn_axis_tready  input  PORTS  per-port ready
busy  output  1  high while a packet is open (between first beat and tlast)
drop_cnt  output  DROP_CNT_WIDTH  count of dropped packets, wraps at 2^DROP_CNT_WIDTH

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - mn_axis_tvalid=0, s_axis_tready=0, busy=0, drop_cnt=0.
  - The main and skid registers are emptied.
  - The start-of-packet flag sop is set to 1.
  - s_axis_tready rises on the first edge after rst_n returns high.
- Reset applied mid-packet: all in-flight beats are discarded, and no partial tail is emitted after release.
- Beat acceptance: a beat is accepted when s_axis_tvalid and s_axis_tready are both high.
  - s_axis_tready = registered (skid register empty).
- Routing state machine (sop flag plus drop flag):
  - IDLE (sop=1): on an accepted beat, sample s_axis_tdest.
    - If tdest < PORTS: latch it into dest_q and go to PASS.
    - Otherwise: go to DROP.
  - PASS: every accepted beat is tagged with dest_q. On an accepted beat with tlast=1, return to IDLE.
  - DROP: accepted beats are discarded (they never enter the output registers).
    - On the accepted tlast beat, return to IDLE and increment drop_cnt by 1.
    - s_axis_tready stays asserted per the normal rule, so a dropped packet drains at 1 beat/cycle.
  - A single-beat packet (first beat with tlast=1) uses the sampled tdest for that beat only and stays in IDLE. If that tdest is invalid, drop_cnt is incremented.
  - tdest on non-first beats is ignored.
  - busy = !sop.
- Output stage:
  - The main register holds {data, keep, user, last, dest}. mn_axis_tvalid = main_valid << main_dest.
  - A beat leaves the main register when mn_axis_tready[main_dest] is high.
  - If the main register is full and not draining, an accepted beat goes to the skid register. s_axis_tready then drops on the next cycle.
  - When the main register drains, the skid contents move into it.
  - Latency is 1 cycle from input acceptance to the output valid.
  - Sustained throughput is 1 beat/cycle while the destination port holds ready high.
- AXI rules:
  - Output tvalid is never deasserted, and output payload never changes, until the beat is taken.
  - Back-to-back packets to different ports proceed without bubbles. Head-of-line blocking is inherent: a stalled port stalls all traffic.
- Width rule: comparing tdest against PORTS matters only when PORTS is not a power of two. When PORTS = 2^PORT_BITS, no drops occur.

Test Plan:
- PORTS=4: send a 3-beat packet with tdest=2 (data 0x11, 0x22, 0x33), all readies high -> mn_axis_tvalid=4'b0100 for 3 consecutive cycles starting 1 cycle after acceptance; tlast only on 0x33; busy high for 2 cycles.
- PORTS=3: send a 4-beat packet with tdest=3, then a 1-beat packet with tdest=0 -> no output valid for the first packet; drop_cnt goes 0->1; the single beat appears on port 0 one cycle after its acceptance.
- Packet to port 1 with mn_axis_tready[1]=0 for 5 cycles mid-packet, continuous input -> s_axis_tready falls after the skid register fills; no beat is lost or duplicated; output payload is stable while stalled; order is preserved.
- Change tdest to 0 on beats 2..4 of a 4-beat packet started with tdest=1 -> all 4 beats exit port 1.
- Back-to-back 2-beat packets to ports 0, 1, 0 with all readies high -> 6 output beats in 6 consecutive cycles with valids 0001, 0001, 0010, 0010, 0001, 0001.
- Assert rst_n=0 for 1 cycle during beat 2 of a 4-beat packet -> all valids 0 and drop_cnt=0; the next packet, tdest=3, routes correctly to port 3 (PORTS=4).
